// File: rtl/conv_stream_engine.sv
// conv_stream_engine
//
// Purpose: stores a CONV_DIM x CONV_DIM signed kernel and a MATRIX_DIM x
// MATRIX_DIM signed matrix. Both are loaded row-major through a valid/ready
// stream. On start, the block slides the kernel over the matrix with a
// run-time stride of 1 or 2. It computes one window sum per CONV_DIM^2
// cycles and emits each sum on a back-pressured output stream.
//
// Optional feature: define CONV_RELU_EN to clamp negative window sums to 0
// on out_data. Without it, the raw wrapped signed sum is emitted. Handshakes
// and timing are the same either way.
//
// Handshake semantics (both streams): a transfer happens on a rising clk
// edge where valid and ready are both high. A producer holding valid keeps
// its data stable until that edge. in_ready does not depend on in_valid.
// out_valid and out_data do not depend on out_ready.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset
//   in_valid   load word valid
//   in_ready   load word accepted (high only in IDLE)
//   in_sel     0 = kernel word, 1 = matrix word
//   in_data    signed load word
//   start      begin a run (sampled in IDLE only)
//   stride     0 = stride 1, 1 = stride 2 (latched on accepted start)
//   busy       high outside IDLE
//   out_valid  window sum valid
//   out_ready  consumer accepts the window sum
//   out_data   signed window sum (ACC_WIDTH bits, wraps modulo 2^ACC_WIDTH)
//   out_last   marks the final window of a run
//   done       one-cycle pulse after the final result is accepted
//   dbg_state  current FSM state (0 IDLE, 1 COMPUTE, 2 OUTPUT, 3 DONE)
module conv_stream_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int MATRIX_DIM = 16,
    parameter int CONV_DIM   = 3,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(CONV_DIM*CONV_DIM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sel,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  start,
    input  logic                  stride,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic                  out_last,
    output logic                  done,
    output logic [1:0]            dbg_state
);

    localparam int KN  = CONV_DIM * CONV_DIM;
    localparam int MN  = MATRIX_DIM * MATRIX_DIM;
    localparam int KIW = (KN > 1) ? $clog2(KN) : 1;
    localparam int MIW = (MN > 1) ? $clog2(MN) : 1;
    localparam int RW  = $clog2(MATRIX_DIM) + 1;
    localparam int CW  = $clog2(CONV_DIM) + 1;
    localparam int N1  = MATRIX_DIM - CONV_DIM + 1;
    localparam int N2  = (MATRIX_DIM - CONV_DIM) / 2 + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_OUTPUT  = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t state, state_nx;

    logic signed [DATA_WIDTH-1:0] kernel_mem [KN];
    logic signed [DATA_WIDTH-1:0] matrix_mem [MN];

    logic [KIW-1:0]               k_ptr;
    logic [MIW-1:0]               m_ptr;
    logic                         stride_q;
    logic [CW-1:0]                tap_i;
    logic [CW-1:0]                tap_j;
    logic [KIW-1:0]               tap_k;
    logic [RW-1:0]                win_r;
    logic [RW-1:0]                win_c;
    logic [RW-1:0]                n_last;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  result;

    logic [RW-1:0]                m_row;
    logic [RW-1:0]                m_col;
    logic [MIW-1:0]               m_idx;
    logic signed [2*DATA_WIDTH-1:0] prod;

    logic tap_first;
    logic tap_last;
    logic win_last;
    logic load_fire;
    logic start_fire;
    logic out_fire;

    // The last window index on each axis depends on the latched stride.
    assign n_last = stride_q ? RW'(N2 - 1) : RW'(N1 - 1);

    // Matrix element under the current tap. The window base is
    // (win_r*S, win_c*S). S is 1 or 2, so the multiply is a shift.
    assign m_row = RW'(win_r << stride_q) + RW'(tap_i);
    assign m_col = RW'(win_c << stride_q) + RW'(tap_j);
    assign m_idx = MIW'(m_row) * MIW'(MATRIX_DIM) + MIW'(m_col);
    assign prod  = kernel_mem[tap_k] * matrix_mem[m_idx];

    assign tap_first  = (tap_k == '0);
    assign tap_last   = (tap_k == KIW'(KN - 1));
    assign win_last   = (win_r == n_last) && (win_c == n_last);
    assign load_fire  = in_valid && (state == S_IDLE);
    assign start_fire = start && (state == S_IDLE);
    assign out_fire   = out_ready && (state == S_OUTPUT);

`ifdef CONV_RELU_EN
    // Negative detection uses the wrapped accumulator sign bit.
    assign result = acc[ACC_WIDTH-1] ? '0 : acc;
`else
    assign result = acc;
`endif

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (start) begin
                    state_nx = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (tap_last) begin
                    state_nx = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                out_valid = 1'b1;
                out_data  = result;
                out_last  = win_last;
                if (out_ready) begin
                    state_nx = win_last ? S_DONE : S_COMPUTE;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < KN; i++) begin
                kernel_mem[i] <= '0;
            end
            for (int i = 0; i < MN; i++) begin
                matrix_mem[i] <= '0;
            end
            k_ptr    <= '0;
            m_ptr    <= '0;
            stride_q <= 1'b0;
            tap_i    <= '0;
            tap_j    <= '0;
            tap_k    <= '0;
            win_r    <= '0;
            win_c    <= '0;
            acc      <= '0;
        end else begin
            if (load_fire) begin
                if (in_sel) begin
                    matrix_mem[m_ptr] <= in_data;
                    m_ptr <= (m_ptr == MIW'(MN - 1)) ? '0 : m_ptr + 1'b1;
                end else begin
                    kernel_mem[k_ptr] <= in_data;
                    k_ptr <= (k_ptr == KIW'(KN - 1)) ? '0 : k_ptr + 1'b1;
                end
            end

            // Placed after the load so a word arriving with start is still
            // written. The pointer clear then takes priority.
            if (start_fire) begin
                k_ptr    <= '0;
                m_ptr    <= '0;
                stride_q <= stride;
                tap_i    <= '0;
                tap_j    <= '0;
                tap_k    <= '0;
                win_r    <= '0;
                win_c    <= '0;
            end

            if (state == S_COMPUTE) begin
                // The first tap overwrites the accumulator, so no separate
                // clear is needed between windows.
                acc <= tap_first ? ACC_WIDTH'(prod) : acc + ACC_WIDTH'(prod);
                if (tap_last) begin
                    tap_i <= '0;
                    tap_j <= '0;
                    tap_k <= '0;
                end else begin
                    tap_k <= tap_k + 1'b1;
                    if (tap_j == CW'(CONV_DIM - 1)) begin
                        tap_j <= '0;
                        tap_i <= tap_i + 1'b1;
                    end else begin
                        tap_j <= tap_j + 1'b1;
                    end
                end
            end

            if (out_fire && !win_last) begin
                if (win_c == n_last) begin
                    win_c <= '0;
                    win_r <= win_r + 1'b1;
                end else begin
                    win_c <= win_c + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_stream_engine.sv
// tb_conv_stream_engine
//
// Purpose: drives conv_stream_engine (MATRIX_DIM=4, CONV_DIM=2) through
// directed and random runs. Every output is compared against a behavioural
// model that recomputes each window sum directly from the stored arrays.
// Ports: none (top-level bench).
module tb_conv_stream_engine;

    localparam int DW      = 8;
    localparam int MD      = 4;
    localparam int CD      = 2;
    localparam int KN      = CD * CD;
    localparam int MN      = MD * MD;
    localparam int AW      = 2*DW + $clog2(KN);
    localparam int TIMEOUT = 200;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_sel;
    logic [DW-1:0] in_data;
    logic          start;
    logic          stride;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_data;
    logic          out_last;
    logic          done;
    logic [1:0]    dbg_state;

    int n_asserts = 0;
    int n_fail    = 0;

    // Scoreboard and reference storage.
    logic [AW-1:0]        exp_q[$];
    logic signed [DW-1:0] kmem [KN];
    logic signed [DW-1:0] mmem [MN];
    int                   kp;
    int                   mp;

    conv_stream_engine #(
        .DATA_WIDTH (DW),
        .MATRIX_DIM (MD),
        .CONV_DIM   (CD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .start     (start),
        .stride    (stride),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < KN; i++) kmem[i] = '0;
        for (int i = 0; i < MN; i++) mmem[i] = '0;
        kp = 0;
        mp = 0;
    endtask

    // Reference: every window sum is computed straight from its definition.
    function automatic void build_expected(input bit s);
        int step;
        int n;
        int total;
        logic [AW-1:0] v;
        step = s ? 2 : 1;
        n    = (MD - CD) / step + 1;
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                total = 0;
                for (int i = 0; i < CD; i++) begin
                    for (int j = 0; j < CD; j++) begin
                        total += int'(kmem[i*CD + j]) * int'(mmem[(r*step + i)*MD + c*step + j]);
                    end
                end
                v = AW'(total);
`ifdef CONV_RELU_EN
                if (v[AW-1]) v = '0;
`endif
                exp_q.push_back(v);
            end
        end
    endfunction

    // Driver: one load word, optionally with start on the same cycle.
    task automatic load_word(input bit sel, input logic [DW-1:0] d, input bit with_start, input bit s);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1'b1);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        start    = with_start;
        stride   = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        start    = 1'b0;
        if (sel) begin
            mmem[mp] = d;
            mp = (mp == MN - 1) ? 0 : mp + 1;
        end else begin
            kmem[kp] = d;
            kp = (kp == KN - 1) ? 0 : kp + 1;
        end
        if (with_start) begin
            kp = 0;
            mp = 0;
            build_expected(s);
        end
    endtask

    task automatic start_run(input bit s);
        @(negedge clk);
        check("start_in_idle", in_ready, 1'b1);
        start  = 1'b1;
        stride = s;
        @(posedge clk);
        #1;
        start = 1'b0;
        kp = 0;
        mp = 0;
        build_expected(s);
    endtask

    // Consumer and scoreboard. stall_first holds out_ready low on the first
    // result. rand_ready adds random stalls on later results. abort_after
    // resets the DUT mid-run after that many results. poke_start pulses
    // start while a result is being held.
    task automatic run_check(input int stall_first, input bit rand_ready,
                             input int abort_after, input bit poke_start);
        int waits;
        int got;
        int stall;
        logic [AW-1:0] held;
        got = 0;
        out_ready = 1'b1;
        while (exp_q.size() > 0) begin
            waits = 0;
            do begin
                @(negedge clk);
                waits++;
            end while (!out_valid && waits < TIMEOUT);
            check("out_valid_arrives", out_valid, 1'b1);
            if (!out_valid) begin
                exp_q.delete();
                return;
            end
            // Every result appears CONV_DIM^2+1 edges after the start or
            // handshake edge. That edge counts as the first.
            check("result_spacing", waits, KN + 1);
            held = exp_q[0];
            check("out_data", out_data, held);
            check("out_last", out_last, exp_q.size() == 1);
            stall = (got == 0) ? stall_first : (rand_ready ? int'($urandom_range(0, 3)) : 0);
            if (stall > 0) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall; s++) begin
                    start  = poke_start && (s == 1);
                    stride = 1'b1;
                    @(negedge clk);
                    check("hold_valid", out_valid, 1'b1);
                    check("hold_data", out_data, held);
                end
                start     = 1'b0;
                out_ready = 1'b1;
            end
            void'(exp_q.pop_front());
            got++;
            if (abort_after != 0 && got == abort_after) begin
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                #1;
                check("abort_out_valid", out_valid, 1'b0);
                check("abort_busy", busy, 1'b0);
                check("abort_in_ready", in_ready, 1'b1);
                check("abort_done", done, 1'b0);
                exp_q.delete();
                clear_model();
                @(negedge clk);
                rst = 1'b1;
                return;
            end
        end
        @(negedge clk);
        check("done_pulse", done, 1'b1);
        check("done_no_valid", out_valid, 1'b0);
        @(negedge clk);
        check("done_drops", done, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 1'b0;
        in_data   = '0;
        start     = 1'b0;
        stride    = 1'b0;
        out_ready = 1'b1;
        clear_model();
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_state", dbg_state, 2'd0);
        rst = 1'b1;

        // Kernel all 1, matrix 0..15, stride 1
        for (int k = 0; k < KN; k++) load_word(1'b0, 8'd1, 1'b0, 1'b0);
        for (int m = 0; m < MN; m++) load_word(1'b1, DW'(m), 1'b0, 1'b0);
        start_run(1'b0);
        check("test1_result_count", exp_q.size(), 9);
        run_check(0, 1'b0, 0, 1'b0);

        // Same data, stride 2
        start_run(1'b1);
        check("stride2_result_count", exp_q.size(), 4);
        run_check(0, 1'b0, 0, 1'b0);

        // Back-pressure on the first result; storage persists without reload
        start_run(1'b0);
        run_check(7, 1'b0, 0, 1'b0);

        // Kernel all -1
        for (int k = 0; k < KN; k++) load_word(1'b0, 8'hFF, 1'b0, 1'b0);
        start_run(1'b0);
        run_check(0, 1'b0, 0, 1'b0);

        // Reset during the third window's COMPUTE, then restart with no reload
        start_run(1'b0);
        run_check(0, 1'b0, 2, 1'b0);
        @(negedge clk);
        check("post_abort_state", dbg_state, 2'd0);
        start_run(1'b0);
        run_check(0, 1'b0, 0, 1'b0);

        // Five kernel words wrap (entry 0 becomes 7); start poked during OUTPUT
        load_word(1'b0, 8'd3, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) load_word(1'b0, 8'd1, 1'b0, 1'b0);
        load_word(1'b0, 8'd7, 1'b0, 1'b0);
        for (int m = 0; m < MN; m++) load_word(1'b1, DW'(m), 1'b0, 1'b0);
        start_run(1'b0);
        run_check(4, 1'b0, 0, 1'b1);

        // Random data and stride, random back-pressure; last matrix word
        // arrives together with start
        for (int t = 0; t < 3; t++) begin
            bit s;
            s = 1'($urandom_range(0, 1));
            for (int k = 0; k < KN; k++) load_word(1'b0, DW'($urandom_range(0, 255)), 1'b0, 1'b0);
            for (int m = 0; m < MN; m++) begin
                load_word(1'b1, DW'($urandom_range(0, 255)), m == MN - 1, s);
            end
            run_check(0, 1'b1, 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_stream_engine.md
Name: conv_stream_engine

Overview:
- Parametrised successor to the single-MAC convolution datapath.
- Stores a CONV_DIM x CONV_DIM kernel and a MATRIX_DIM x MATRIX_DIM input matrix, both loaded row-major through a valid/ready stream.
- On start, slides the kernel over the matrix with a run-time stride of 1 or 2 and accumulates one window per CONV_DIM^2 cycles.
- Emits each signed result on a back-pressured output stream, marks the last result, and pulses done.

Parameters:
- DATA_WIDTH, 8, signed element width for kernel and matrix entries.
- MATRIX_DIM, 16, input matrix side length (>= CONV_DIM).
- CONV_DIM, 3, kernel side length (>= 1).
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(CONV_DIM*CONV_DIM), signed accumulator and output width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-low.
- in_valid  in  1  load word valid.
- in_ready  out  1  load word accepted when in_valid & in_ready.
- in_sel  in  1  0 = kernel word, 1 = matrix word.
- in_data  in  DATA_WIDTH  signed load word.
- start  in  1  begin convolution (sampled in IDLE only).
- stride  in  1  0 = stride 1, 1 = stride 2; latched on accepted start.
- busy  out  1  high outside IDLE.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  ACC_WIDTH  signed window sum.
- out_last  out  1  qualifies the final result of a run.
- done  out  1  one-cycle pulse after the final result is accepted.

Behaviour:
- Reset (rst low, async): state IDLE. Kernel and matrix storage, load pointers, window and tap counters, and the accumulator clear to 0. Outputs: in_ready=1, busy=0, out_valid=0, out_data=0, out_last=0, done=0.
- Loading:
  - in_ready=1 only in IDLE.
  - An accepted word is written at the pointer for its in_sel, and that pointer then increments.
  - Kernel pointer wraps at CONV_DIM^2-1 -> 0; matrix pointer wraps at MATRIX_DIM^2-1 -> 0. Extra words overwrite from entry 0.
  - Pointers clear on accepted start.
- start in IDLE -> COMPUTE on the next edge.
  - Loads need not be complete; unloaded entries hold their previous values (0 after reset).
  - If in_valid and start coincide in IDLE, the word is written and start is also accepted.
- Output grid: N = (MATRIX_DIM-CONV_DIM)/S + 1 per axis, with S = 1 or 2 (integer division). Windows are scanned row-major with base (r*S, c*S).
- COMPUTE:
  - Runs exactly CONV_DIM^2 cycles. The tap counter scans kernel (i,j) row-major.
  - acc <= acc + kernel[i][j]*matrix[r*S+i][c*S+j], signed.
  - The first tap loads the product into the accumulator rather than adding to it.
  - Sums wrap modulo 2^ACC_WIDTH; no saturation.
  - After the last tap -> OUTPUT.
- OUTPUT:
  - out_valid=1 and out_data holds the sum, stable until out_ready.
  - out_last=1 when the window is (N-1, N-1).
  - On handshake: if not last, advance the window and go to COMPUTE; if last, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Latency: first out_valid rises CONV_DIM^2+1 edges after the edge sampling start. With out_ready held high, results are spaced CONV_DIM^2+1 cycles apart.
- start is ignored outside IDLE.
- Stored kernel and matrix contents persist across runs; a second start with no reload reproduces the same results.
- Reset mid-run aborts immediately to IDLE with storage cleared. No done pulse is generated.

Optional Feature:
- Macro CONV_RELU_EN.
  - Defined: out_data = (sum < 0) ? 0 : sum. Negative detection uses the wrapped ACC_WIDTH value.
  - Undefined: out_data = raw signed sum.
- Handshakes and timing are identical in both cases.

Test Plan:
- MATRIX_DIM=4, CONV_DIM=2, kernel all 1, matrix 0..15 row-major, stride=0, out_ready=1 -> 9 results: 10,14,18,26,30,34,42,46,50. out_last on 50, done 1 cycle later, first out_valid 5 edges after start.
- Same data, stride=1 -> 4 results 10,18,42,50 in that order; out_last on 50.
- out_ready low for 7 cycles on the first result -> out_data holds 10 and out_valid stays high; no tap progress; the sequence then resumes unchanged.
- Kernel all -1, stride=0 -> first result -10 (two's complement in ACC_WIDTH) without CONV_RELU_EN; all 9 results 0 with CONV_RELU_EN.
- rst low during the 3rd window's COMPUTE -> out_valid=0, busy=0, in_ready=1 asynchronously. A restart without reload gives all-zero results.
- Load 5 kernel words (wrap, 5th overwrites entry 0 with 7), matrix 0..15, stride=0 -> first result 7*0+1+4+5=10, second 7*1+2+5+6=20; start asserted during OUTPUT is ignored.
